// File: rtl/des_f_pipe.sv
// DES round function f(R,K) = P(S(E(R) ^ K)), two registered stages (x1, f_out).
// Latency 2 clocks from accept to out_valid; one result per clock when unstalled.
// Backpressure: out_ready low holds both stages; in_ready drops only when both are full.

module des_f_sbox #(
    parameter int BOX = 1
) (
    input  logic [5:0] din,
    output logic [3:0] dout
);
    // Row-major 4x16 tables, entry 0 in the most significant nibble.
    localparam logic [255:0] TBL =
        (BOX == 1) ? 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D :
        (BOX == 2) ? 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9 :
        (BOX == 3) ? 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C :
        (BOX == 4) ? 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E :
        (BOX == 5) ? 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453 :
        (BOX == 6) ? 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D :
        (BOX == 7) ? 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C :
                     256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

    logic [5:0] idx;
    logic [7:0] msb;

    assign idx  = {din[5], din[0], din[4:1]};
    assign msb  = 8'd255 - {idx, 2'b00};
    assign dout = TBL[msb -: 4];
endmodule

module des_f_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] r_in,
    input  logic [47:0] k_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] f_out
);
    logic [47:0] e;
    logic [47:0] x1;
    logic        v1;
    logic        v2;
    logic        adv1;
    logic        adv2;
    logic [31:0] s;
    logic [31:0] p;

    // E expansion: DES bit n of R lives at r_in[32-n].
    assign e = {r_in[0],     r_in[31:27], r_in[28:23], r_in[24:19],
                r_in[20:15], r_in[16:11], r_in[12:7],  r_in[8:3],
                r_in[4:0],   r_in[31]};

    des_f_sbox #(.BOX(1)) sbox1 (.din(x1[47:42]), .dout(s[31:28]));
    des_f_sbox #(.BOX(2)) sbox2 (.din(x1[41:36]), .dout(s[27:24]));
    des_f_sbox #(.BOX(3)) sbox3 (.din(x1[35:30]), .dout(s[23:20]));
    des_f_sbox #(.BOX(4)) sbox4 (.din(x1[29:24]), .dout(s[19:16]));
    des_f_sbox #(.BOX(5)) sbox5 (.din(x1[23:18]), .dout(s[15:12]));
    des_f_sbox #(.BOX(6)) sbox6 (.din(x1[17:12]), .dout(s[11:8]));
    des_f_sbox #(.BOX(7)) sbox7 (.din(x1[11:6]),  .dout(s[7:4]));
    des_f_sbox #(.BOX(8)) sbox8 (.din(x1[5:0]),   .dout(s[3:0]));

    assign p = {s[16], s[25], s[12], s[11], s[3],  s[20], s[4],  s[15],
                s[31], s[17], s[9],  s[6],  s[27], s[14], s[1],  s[22],
                s[30], s[24], s[8],  s[18], s[0],  s[5],  s[29], s[23],
                s[13], s[19], s[2],  s[26], s[10], s[21], s[28], s[7]};

    assign adv2      = !v2 || out_ready;
    assign adv1      = !v1 || adv2;
    assign in_ready  = adv1;
    assign out_valid = v2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            x1 <= '0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                x1 <= e ^ k_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            f_out <= '0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                f_out <= p;
            end
        end
    end
endmodule

// File: tb/tb_des_f_pipe.sv
// Bench for des_f_pipe: directed vectors, streaming, backpressure, random stalls, reset mid-flight,
// all scored against a table-driven model of f(R,K).
module tb_des_f_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] r_in = '0;
    logic [47:0] k_in = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] f_out;

    int n_vec = 0;
    int n_err = 0;

    des_f_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .r_in(r_in), .k_in(k_in), .out_valid(out_valid), .out_ready(out_ready),
        .f_out(f_out)
    );

    always #5 clk = ~clk;

    int E_TAB [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
                       12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23,
                       24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    int P_TAB [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                       2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    int SB [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    function automatic logic [31:0] f_ref(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] f;
        logic [5:0]  c;
        int          row;
        int          col;
        for (int i = 1; i <= 48; i++) x[48-i] = r[32-E_TAB[i-1]];
        x = x ^ k;
        for (int b = 0; b < 8; b++) begin
            c   = x[47-6*b -: 6];
            row = 2 * int'(c[5]) + int'(c[0]);
            col = int'(c[4:1]);
            s[31-4*b -: 4] = 4'(SB[b][row*16+col]);
        end
        for (int i = 1; i <= 32; i++) f[32-i] = s[32-P_TAB[i-1]];
        return f;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: samples handshakes mid-cycle, away from the active edge.
    logic [31:0] exp_q[$];
    initial begin
        logic        hold_arm;
        logic [31:0] hold_val;
        hold_arm = 1'b0;
        hold_val = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                hold_arm = 1'b0;
            end else begin
                if (hold_arm) begin
                    check("hold_vld", 64'(out_valid), 64'(1));
                    check("hold_dat", 64'(f_out), 64'(hold_val));
                end
                hold_arm = out_valid && !out_ready;
                hold_val = f_out;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) check("sb_spurious", 64'(exp_q.size()), 64'(1));
                    else check("sb_data", 64'(f_out), 64'(exp_q.pop_front()));
                end
                if (in_valid && in_ready) exp_q.push_back(f_ref(r_in, k_in));
            end
        end
    end

    initial begin
        logic [31:0] ra, rb, rc;
        logic [47:0] ka, kb, kc;
        int first_ov, last_ov, n_ov;

        #2;
        check("rst_ov", 64'(out_valid), 64'(0));
        check("rst_f", 64'(f_out), 64'(0));
        check("rst_x1", 64'(dut.x1), 64'(0));
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        edge1();
        @(negedge clk);
        check("rst_ir", 64'(in_ready), 64'(1));
        edge1();

        // Known vector
        out_ready = 1'b1;
        in_valid  = 1'b1;
        r_in = 32'hF0AAF0AA;
        k_in = 48'h1B02EFFC7072;
        @(negedge clk);
        check("kv_ir", 64'(in_ready), 64'(1));
        edge1();
        in_valid = 1'b0;
        r_in = $urandom;
        k_in = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        @(negedge clk);
        check("kv_x1", 64'(dut.x1), 64'h6117BA866527);
        check("kv_ov0", 64'(out_valid), 64'(0));
        edge1();
        @(negedge clk);
        check("kv_ov1", 64'(out_valid), 64'(1));
        check("kv_f", 64'(f_out), 64'h234AA9BB);
        edge1();
        @(negedge clk);
        check("kv_ov2", 64'(out_valid), 64'(0));
        edge1();

        // Zero vector
        in_valid = 1'b1;
        r_in = '0;
        k_in = '0;
        @(negedge clk);
        edge1();
        in_valid = 1'b0;
        @(negedge clk);
        edge1();
        @(negedge clk);
        check("zero_ov", 64'(out_valid), 64'(1));
        check("zero_f", 64'(f_out), 64'hD8D8DBBC);
        edge1();

        // Streaming: 16 back-to-back
        first_ov = -1;
        last_ov  = -1;
        n_ov     = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = (i < 16);
            r_in = $urandom;
            k_in = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
            @(negedge clk);
            if (i < 16) check("strm_ir", 64'(in_ready), 64'(1));
            if (out_valid) begin
                n_ov++;
                if (first_ov < 0) first_ov = i;
                last_ov = i;
            end
            edge1();
        end
        in_valid = 1'b0;
        check("strm_first", 64'(first_ov), 64'(2));
        check("strm_cnt", 64'(n_ov), 64'(16));
        check("strm_last", 64'(last_ov), 64'(17));

        // Backpressure
        out_ready = 1'b0;
        ra = $urandom; ka = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        rb = $urandom; kb = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        rc = $urandom; kc = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        in_valid = 1'b1;
        r_in = ra; k_in = ka;
        @(negedge clk);
        check("bp_ir_a", 64'(in_ready), 64'(1));
        edge1();
        r_in = rb; k_in = kb;
        @(negedge clk);
        check("bp_ir_b", 64'(in_ready), 64'(1));
        edge1();
        r_in = rc; k_in = kc;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_ir_full", 64'(in_ready), 64'(0));
            check("bp_ov", 64'(out_valid), 64'(1));
            check("bp_f_a", 64'(f_out), 64'(f_ref(ra, ka)));
            edge1();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_ir_rel", 64'(in_ready), 64'(1));
        check("bp_rel_a", 64'(f_out), 64'(f_ref(ra, ka)));
        edge1();
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_ov_b", 64'(out_valid), 64'(1));
        check("bp_rel_b", 64'(f_out), 64'(f_ref(rb, kb)));
        edge1();
        @(negedge clk);
        check("bp_ov_c", 64'(out_valid), 64'(1));
        check("bp_rel_c", 64'(f_out), 64'(f_ref(rc, kc)));
        edge1();
        @(negedge clk);
        check("bp_empty", 64'(out_valid), 64'(0));
        edge1();

        // Random valid / stall
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 6);
            r_in = $urandom;
            k_in = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
            @(negedge clk);
            edge1();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) edge1();
        @(negedge clk);
        check("rnd_drain", 64'(exp_q.size()), 64'(0));
        check("rnd_ov_idle", 64'(out_valid), 64'(0));
        edge1();

        // Reset mid-flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            r_in = $urandom;
            k_in = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
            @(negedge clk);
            check("mf_ir", 64'(in_ready), 64'(1));
            edge1();
        end
        in_valid = 1'b0;
        check("mf_pre_ov", 64'(out_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("mf_ov", 64'(out_valid), 64'(0));
        check("mf_f", 64'(f_out), 64'(0));
        check("mf_x1", 64'(dut.x1), 64'(0));
        #3 rst_n = 1'b1;
        edge1();
        out_ready = 1'b1;
        @(negedge clk);
        check("mf_ir_rel", 64'(in_ready), 64'(1));
        edge1();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("mf_stale", 64'(out_valid), 64'(0));
            edge1();
        end
        check("end_q", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
